cmp_sort_seq: RTL and testbench

- Sequencer that owns one shared 5-bit subtract-and-borrow compare unit and uses it to sort a block of N unsigned words.
- Accepts N words over a valid/ready input stream, then runs bubble-sort passes with one compare per cycle.
- Streams the sorted block out in ascending order on a valid/ready output.
- Sits between a word producer and any consumer that needs ordered operands, such as a min/max selector.

---
 rtl/cmp_sort_seq_if.sv | 26 ++
 rtl/cmp_sort_seq.sv | 152 +++++++++++++++
 tb/tb_cmp_sort_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_sort_seq_if.sv
// Stream interface for cmp_sort_seq: load stream in, sorted stream out,
// plus the busy/out_last status flags.
interface cmp_sort_seq_if #(
  parameter int W = 5
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         out_last;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, out_last
  );

  // Sorter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, out_last
  );
endinterface

// File: rtl/cmp_sort_seq.sv
// cmp_sort_seq: loads N words, bubble-sorts them with one shared
// subtract-and-borrow compare per cycle, then drains them in ascending order.
// Optional macro CMP_SORT_SWAP_CNT_EN adds a saturating 6-bit swap counter port.
module cmp_sort_seq #(
  parameter int N = 4,
  parameter int W = 5
) (
  input  logic              clk,
  input  logic              rst,
  cmp_sort_seq_if.slave     bus
`ifdef CMP_SORT_SWAP_CNT_EN
  ,
  output logic [5:0]        swap_cnt
`endif
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] LAST_J    = IW'(N - 2);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t        state, state_next;
  logic [W-1:0]  mem [N];
  logic [IW-1:0] wr_idx, rd_idx, j, pass_cnt;
  logic [IW-1:0] j_nxt;
  logic          swapped;
  logic          in_ready_r;

  logic          accept, take;
  logic          out_valid, busy, out_last;
  logic [W-1:0]  out_data;

  // Shared compare unit: W-bit difference with borrow out of the MSB
  logic [W-1:0]  cmp_a, cmp_b, diff;
  logic          borrow, gt, sort_done;

  assign j_nxt = j + IW'(1);

  // Compare mem[j] against mem[j+1]; greater = no borrow and nonzero difference
  always_comb begin
    cmp_a         = mem[j];
    cmp_b         = mem[j_nxt];
    {borrow, diff} = {1'b0, cmp_a} - {1'b0, cmp_b};
    gt            = !borrow && (diff != '0);
    // the current compare's swap counts toward the early-exit decision
    sort_done     = (j == LAST_J) && (!(swapped || gt) || (pass_cnt == LAST_PASS));
  end

  assign accept = bus.in_valid && in_ready_r && (state == LOAD);
  assign take   = out_valid && bus.out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    case (state)
      LOAD: begin
        if (accept && (wr_idx == LAST_IDX)) state_next = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        out_last  = (rd_idx == LAST_IDX);
        if (take && out_last) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // in_ready is registered: it simply anticipates being in LOAD next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready_r <= 1'b0;
    else     in_ready_r <= (state_next == LOAD);
  end

  // Storage, indices, pass tracking and swap bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      j        <= '0;
      pass_cnt <= '0;
      swapped  <= 1'b0;
`ifdef CMP_SORT_SWAP_CNT_EN
      swap_cnt <= '0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            mem[wr_idx] <= bus.in_data;
            if (wr_idx == LAST_IDX) begin
              wr_idx   <= '0;
              j        <= '0;
              pass_cnt <= '0;
              swapped  <= 1'b0;
`ifdef CMP_SORT_SWAP_CNT_EN
              swap_cnt <= '0;
`endif
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        SORT: begin
          if (gt) begin
            mem[j]     <= mem[j_nxt];
            mem[j_nxt] <= mem[j];
`ifdef CMP_SORT_SWAP_CNT_EN
            if (swap_cnt != 6'd63) swap_cnt <= swap_cnt + 6'd1;
`endif
          end
          if (j == LAST_J) begin
            j        <= '0;
            swapped  <= 1'b0;
            pass_cnt <= pass_cnt + IW'(1);
          end else begin
            j       <= j_nxt;
            swapped <= swapped || gt;
          end
        end
        DRAIN: begin
          if (take) rd_idx <= out_last ? '0 : rd_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.busy      = busy;
  assign bus.out_last  = out_last;

endmodule

// File: tb/tb_cmp_sort_seq.sv
// Scoreboard bench for cmp_sort_seq: directed blocks plus random blocks,
// expected order from a queue sort, busy length and swap count from
// inversion counts of the loaded block.
module tb_cmp_sort_seq;
  localparam int N = 4;
  localparam int W = 5;

  typedef logic [W-1:0] blk_t [N];
  typedef struct {
    logic [W-1:0] data;
    bit           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_sort_seq_if #(.W(W)) bus ();
`ifdef CMP_SORT_SWAP_CNT_EN
  logic [5:0] swap_cnt;
`endif

  cmp_sort_seq #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef CMP_SORT_SWAP_CNT_EN
    ,
    .swap_cnt (swap_cnt)
`endif
  );

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int taken = 0;
  int bp_mode = 0;
  int hold  = 0;

  function automatic void check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Consumer: out_ready changes well after the rising edge
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if ((taken % N == 1) && hold < 5) begin
            bus.out_ready = 1'b0;
            hold++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stale_word: got %0d expected no output", bus.out_data);
        end else begin
          check("out_data", int'(bus.out_data), int'(sb[0].data));
          check("out_last", int'(bus.out_last), int'(sb[0].last));
          check("in_ready_in_drain", int'(bus.in_ready), 0);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            taken++;
          end
        end
      end
    end
  endtask

  task automatic load_block(input blk_t w, input bit use_bits, input int bits, output bit ok);
    int idx = 0;
    int k = 0;
    bit v;
    ok = 1'b0;
    while (idx < N && k < 200) begin
      @(negedge clk);
      v = use_bits ? ((k < 16) ? bits[k] : 1'b1) : ($urandom_range(0, 3) != 0);
      k++;
      bus.in_valid = v;
      bus.in_data  = v ? w[idx] : W'($urandom_range(0, (1 << W) - 1));
      if (v && bus.in_ready) idx++;
    end
    if (idx < N) begin
      total++;
      bad++;
      $display("FAIL load_timeout: got %0d words expected %0d", idx, N);
    end else begin
      ok = 1'b1;
    end
  endtask

  task automatic run_block(input blk_t w, input bit use_bits, input int bits);
    logic [W-1:0] q[$];
    int inv = 0;
    int lmax = 0;
    int c, passes, exp_busy, cnt, guard;
    bit ok;
    for (int k = 0; k < N; k++) begin
      c = 0;
      for (int i = 0; i < k; i++) if (w[i] > w[k]) c++;
      inv += c;
      if (c > lmax) lmax = c;
      q.push_back(w[k]);
    end
    passes   = (lmax + 1 < N - 1) ? lmax + 1 : N - 1;
    exp_busy = passes * (N - 1);
    q.sort();

    load_block(w, use_bits, bits, ok);
    if (!ok) return;
    for (int i = 0; i < N; i++) sb.push_back('{data: q[i], last: (i == N - 1)});

    // junk on the input during SORT must be ignored
    cnt = 0;
    guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.out_valid) break;
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom_range(0, (1 << W) - 1));
      if (bus.busy) cnt++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL sort_timeout: got %0d busy cycles without output", cnt);
    end
    check("busy_cycles", cnt, exp_busy);
`ifdef CMP_SORT_SWAP_CNT_EN
    check("swap_cnt", int'(swap_cnt), (inv > 63) ? 63 : inv);
`endif

    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d words left expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    check("in_ready_after_drain", int'(bus.in_ready), 1);
    check("busy_after_drain", int'(bus.busy), 0);
`ifdef CMP_SORT_SWAP_CNT_EN
    check("swap_cnt_held", int'(swap_cnt), (inv > 63) ? 63 : inv);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  int'(bus.in_ready), 0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_data"},  int'(bus.out_data), 0);
    check({tag, "_busy"},      int'(bus.busy), 0);
    check({tag, "_out_last"},  int'(bus.out_last), 0);
`ifdef CMP_SORT_SWAP_CNT_EN
    check({tag, "_swap_cnt"},  int'(swap_cnt), 0);
`endif
  endtask

  task automatic stimulus();
    blk_t w;
    bit ok;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_at_release", int'(bus.in_ready), 0);
    @(negedge clk);
    check("in_ready_after_release", int'(bus.in_ready), 1);

    w = '{31, 20, 5, 0};  run_block(w, 1'b1, 32'hFFFF);
    w = '{2, 4, 6, 8};    run_block(w, 1'b1, 32'hFFFF);
    w = '{31, 0, 31, 0};  run_block(w, 1'b1, 32'hFFFF);

    hold = 0;
    bp_mode = 2;
    w = '{10, 1, 10, 1};  run_block(w, 1'b1, 32'hFFFF);
    bp_mode = 0;

    // valid pattern 1,0,0,1,1,0,1
    w = '{7, 6, 5, 4};    run_block(w, 1'b1, 32'h59);

    // reset in the middle of SORT
    w = '{9, 3, 7, 1};
    load_block(w, 1'b1, 32'hFFFF, ok);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("busy_before_reset", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_mid_reset", int'(bus.in_ready), 1);
    repeat (3) @(negedge clk);

    bp_mode = 1;
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < N; i++)
        w[i] = (b % 3 == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, (1 << W) - 1));
      run_block(w, 1'b0, 0);
    end
    bp_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
